seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 144 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider, one quotient bit per clock.
// Operands are captured on an accepted start pulse. Quotient and remainder are
// returned with a one-cycle done pulse and then held until the next start.
// Optional macro SIGNED_DIV_EN selects two's-complement operands. The iteration
// runs on magnitudes, and an extra FIXUP cycle restores the result signs.
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
`ifdef SIGNED_DIV_EN
    logic             r_negQ;
    logic             r_negR;
`endif

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH-1:0] w_dividendMag;
    logic [WIDTH-1:0] w_divisorMag;

    // The partial remainder is conceptually WIDTH+1 bits wide, but after each
    // step it is always below the divisor. Its top bit is therefore always zero,
    // so only WIDTH bits are stored and the extra bit lives only in w_shifted.
    assign w_shifted = {r_rem, r_q[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_remNext = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_qNext   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};

`ifdef SIGNED_DIV_EN
    assign w_dividendMag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_divisorMag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
    assign w_dividendMag = dividend;
    assign w_divisorMag  = divisor;
`endif

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
`ifdef SIGNED_DIV_EN
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state   <= S_CALC;
                            busy      <= 1'b1;
                            r_count   <= '0;
                            r_rem     <= '0;
                            r_q       <= w_dividendMag;
                            r_divisor <= w_divisorMag;
`ifdef SIGNED_DIV_EN
                            r_negQ    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_negR    <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_remNext;
                    r_q     <= w_qNext;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_COUNT) begin
`ifdef SIGNED_DIV_EN
                        r_state   <= S_FIXUP;
`else
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= w_qNext;
                        remainder <= w_remNext;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                S_FIXUP: begin
                    r_state   <= S_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= r_negQ ? (~r_q + 1'b1) : r_q;
                    remainder <= r_negR ? (~r_rem + 1'b1) : r_rem;
                end
`endif
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: self-checking bench for seq_restoring_divider.
// Expected results come from plain integer division in a reference function.
// Defining SIGNED_DIV_EN switches the model and latency to the signed build.
module tb_seq_restoring_divider;

    localparam int WIDTH = 32;
`ifdef SIGNED_DIV_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int compareCount = 0;
    int failCount = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Absolute watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference division computed straight from the arithmetic rules.
    function automatic void modelDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                     output logic dbz, output int lat);
        logic [WIDTH-1:0] minVal;
        minVal = '0;
        minVal[WIDTH-1] = 1'b1;
        dbz = 1'b0;
        lat = LAT;
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1; lat = 0;
        end else begin
`ifdef SIGNED_DIV_EN
            if (a == minVal && b == '1) begin
                q = minVal; r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Present operands with start for exactly one edge (edge k), then scramble them.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    // Step until done is seen or the cycle budget runs out; count busy samples.
    task automatic waitDone(output int cycles, output int busyCnt);
        cycles = 0;
        busyCnt = 0;
        while (done !== 1'b1 && cycles < 4 * WIDTH) begin
            if (busy === 1'b1) busyCnt++;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compareCount++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b q=%h r=%h dbz=%b expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int sawDone;
        applyStimulus(32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        compareCount++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_mid_calc: got busy=%b done=%b q=%h r=%h dbz=%b expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawDone = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) sawDone++;
        end
        compareCount++;
        if (sawDone != 0) begin
            failCount++;
            $display("[TB] FAIL reset_no_done: got %0d active cycles after reset expected 0", sawDone);
        end
    endtask

    task automatic test_basic();
        int cycles, busyCnt;
        applyStimulus(32'd100, 32'd7);
        waitDone(cycles, busyCnt);
        compareCount++;
        if (cycles != LAT) begin
            failCount++;
            $display("[TB] FAIL basic_latency: got %0d expected %0d", cycles, LAT);
        end
        compareCount++;
        if ({quotient, remainder, div_by_zero, busy} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b expected q=14 r=2 dbz=0 busy=0",
                     quotient, remainder, div_by_zero, busy);
        end
        compareCount++;
        if (busyCnt != LAT) begin
            failCount++;
            $display("[TB] FAIL basic_busy: got %0d busy cycles expected %0d", busyCnt, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            compareCount++;
            if ({done, busy, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 32'd14, 32'd2, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL basic_hold%0d: got done=%b busy=%b q=%0d r=%0d dbz=%b expected 0 0 14 2 0",
                         i, done, busy, quotient, remainder, div_by_zero);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int cycles, busyCnt;
        applyStimulus(32'h12345678, 32'd0);
        waitDone(cycles, busyCnt);
        compareCount++;
        if (cycles != 0 || busyCnt != 0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL dbz_timing: got cycles=%0d busyCnt=%0d busy=%b expected 0 0 0",
                     cycles, busyCnt, busy);
        end
        compareCount++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFFFFFF, 32'h12345678, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL dbz_result: got q=%h r=%h dbz=%b expected ffffffff 12345678 1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        compareCount++;
        if ({done, busy, div_by_zero} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL dbz_hold: got done=%b busy=%b dbz=%b expected 0 0 1", done, busy, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] aList [3] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [WIDTH-1:0] bList [3] = '{32'd9, 32'hFFFFFFFF, 32'd1};
        logic [WIDTH-1:0] qExp  [3] = '{32'd0, 32'd1, 32'hFFFFFFFF};
        logic [WIDTH-1:0] rExp  [3] = '{32'd5, 32'd0, 32'd0};
        int cycles, busyCnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(aList[i], bList[i]);
            waitDone(cycles, busyCnt);
            compareCount++;
            if (cycles != LAT || quotient !== qExp[i] || remainder !== rExp[i] || div_by_zero !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL b2b%0d: got lat=%0d q=%h r=%h dbz=%b expected lat=%0d q=%h r=%h dbz=0",
                         i, cycles, quotient, remainder, div_by_zero, LAT, qExp[i], rExp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_while_busy();
        int cycles, busyCnt, extraDone;
        applyStimulus(32'd1000, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(cycles, busyCnt);
        compareCount++;
        if (cycles + 5 != LAT || quotient !== 32'd333 || remainder !== 32'd1) begin
            failCount++;
            $display("[TB] FAIL busy_ignore: got lat=%0d q=%0d r=%0d expected lat=%0d q=333 r=1",
                     cycles + 5, quotient, remainder, LAT);
        end
        extraDone = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) extraDone++;
        end
        compareCount++;
        if (extraDone != 0 || quotient !== 32'd333) begin
            failCount++;
            $display("[TB] FAIL busy_single_done: got extra=%0d q=%0d expected extra=0 q=333", extraDone, quotient);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, qExp, rExp;
        logic             dbzExp;
        int               latExp, cycles, busyCnt;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = (i % 8 == 2) ? '0 : a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            modelDiv(a, b, qExp, rExp, dbzExp, latExp);
            applyStimulus(a, b);
            waitDone(cycles, busyCnt);
            compareCount++;
            if (cycles != latExp || quotient !== qExp || remainder !== rExp || div_by_zero !== dbzExp) begin
                failCount++;
                $display("[TB] FAIL random%0d %h/%h: got lat=%0d q=%h r=%h dbz=%b expected lat=%0d q=%h r=%h dbz=%b",
                         i, a, b, cycles, quotient, remainder, div_by_zero, latExp, qExp, rExp, dbzExp);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [WIDTH-1:0] aList [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [WIDTH-1:0] bList [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [WIDTH-1:0] qExp  [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
        logic [WIDTH-1:0] rExp  [3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
        int cycles, busyCnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(aList[i], bList[i]);
            waitDone(cycles, busyCnt);
            compareCount++;
            if (cycles != WIDTH + 1 || quotient !== qExp[i] || remainder !== rExp[i]) begin
                failCount++;
                $display("[TB] FAIL signed%0d: got lat=%0d q=%h r=%h expected lat=%0d q=%h r=%h",
                         i, cycles, quotient, remainder, WIDTH + 1, qExp[i], rExp[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_reset_mid_calc();
        test_basic();
        test_div_by_zero();
        @(posedge clk); #1;
        test_back_to_back();
        test_start_while_busy();
        test_random();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
